// File: rtl/bcd_pkg.sv
// Constants and state encoding shared by the BCD <-> binary converters.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] DD_THRESH     = 4'd8;
    localparam logic [3:0] DD_CORR       = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic logic digitInvalid(input logic [3:0] digit);
        return digit > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_corrector.sv
// Reverse double-dabble correction for one BCD digit field after a right shift.
module bcd_digit_corrector
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= DD_THRESH) ? (digit_i - DD_CORR) : digit_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with a
// start/busy/done handshake; one shift per clock, BIN_W shifts per conversion.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [BIN_W-1:0]   bin_q;
    logic [WORK_W-1:0]  work_q;
    logic [WORK_W-1:0]  work_d;
    logic [WORK_W-1:0]  shifted;
    logic [CNT_W-1:0]   cnt_q;
    logic               anyInvalid;

    assign shifted = work_q >> 1;

    // Only the digit fields get corrected; the growing binary part passes through.
    for (genvar g = 0; g < DIGITS; g++) begin : gen_corr
        bcd_digit_corrector u_corr (
            .digit_i(shifted[BIN_W + 4*g +: 4]),
            .digit_o(work_d[BIN_W + 4*g +: 4])
        );
    end

    assign work_d[BIN_W-1:0] = shifted[BIN_W-1:0];

    always_comb begin
        anyInvalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digitInvalid(bcd[4*i +: 4])) begin
                anyInvalid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        work_q <= {bcd, {BIN_W{1'b0}}};
                        cnt_q  <= '0;
                        // Bad digits short-circuit straight to DONE with a zero result.
                        if (anyInvalid) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            bin_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bin_q   <= work_d[BIN_W-1:0];
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases, an exhaustive
// decimal sweep and randomized conversions against a decimal reference model.
module tb_bcd_to_binary_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk;
    logic              reset;
    logic              start;
    logic [11:0]       bcd;
    logic              busy;
    logic              done;
    logic              err;
    logic [BIN_W-1:0]  bin;

    int checks;
    int errors;
    logic [11:0] curBcd;

    bcd_to_binary_seq #(
        .DIGITS(DIGITS),
        .BIN_W(BIN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bcd(bcd),
        .busy(busy),
        .done(done),
        .err(err),
        .bin(bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s (bcd=%03h): observed %0d expected %0d", tag, curBcd, observed, expected);
        end
    endtask

    // Decimal reference: value = sum(digit * 10^i); any digit above 9 is an error with result 0.
    task automatic refModel(input logic [11:0] v, output int expBin, output logic expErr);
        int pow;
        int d;
        expBin = 0;
        expErr = 1'b0;
        pow = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((v >> (4*i)) & 12'hF);
            if (d > 9) expErr = 1'b1;
            expBin += d * pow;
            pow *= 10;
        end
        if (expErr) expBin = 0;
    endtask

    task automatic applyStimulus(input logic [11:0] v);
        curBcd = v;
        start  = 1'b1;
        bcd    = v;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic waitDone(input int first, output int lat, output int busyCnt);
        lat = first;
        busyCnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busyCnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convertAndCheck(input logic [11:0] v, input string tag);
        int lat;
        int busyCnt;
        int expBin;
        logic expErr;
        refModel(v, expBin, expErr);
        applyStimulus(v);
        waitDone(1, lat, busyCnt);
        checkOutput({tag, "_lat"}, 32'(lat), expErr ? 32'd1 : 32'(BIN_W + 1));
        checkOutput({tag, "_busy"}, 32'(busyCnt), expErr ? 32'd0 : 32'(BIN_W));
        checkOutput({tag, "_bin"}, 32'(bin), 32'(expBin));
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    endtask

    initial begin
        int lat;
        int busyCnt;
        int doneSeen;
        logic [11:0] v;
        checks = 0;
        errors = 0;
        curBcd = '0;
        start  = 1'b0;
        bcd    = '0;
        reset  = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_bin", 32'(bin), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convertAndCheck(12'h255, "c255");
        @(negedge clk);
        convertAndCheck(12'h999, "c999");
        @(negedge clk);
        convertAndCheck(12'h000, "c000");
        @(negedge clk);
        convertAndCheck(12'h1A3, "c1A3");
        @(negedge clk);

        // Start during SHIFT is ignored, bcd changes are ignored.
        applyStimulus(12'h123);
        repeat (3) @(negedge clk);
        start = 1'b1;
        bcd   = 12'h456;
        @(negedge clk);
        start = 1'b0;
        bcd   = 12'h999;
        waitDone(5, lat, busyCnt);
        checkOutput("ign_lat", 32'(lat), 32'(BIN_W + 1));
        checkOutput("ign_bin", 32'(bin), 32'd123);
        checkOutput("ign_err", 32'(err), 32'd0);

        // Back-to-back start in the DONE cycle.
        convertAndCheck(12'h456, "b2b");
        repeat (3) @(negedge clk);
        checkOutput("hold_bin", 32'(bin), 32'd456);
        checkOutput("hold_done", 32'(done), 32'd0);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        applyStimulus(12'h777);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_err", 32'(err), 32'd0);
        checkOutput("arst_bin", 32'(bin), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkOutput("arst_quiet", 32'(doneSeen), 32'd0);
        convertAndCheck(12'h042, "c042");

        // Exhaustive sweep of every valid three-digit input.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            v = 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
            applyStimulus(v);
            waitDone(1, lat, busyCnt);
            checkOutput("sweep_lat", 32'(lat), 32'(BIN_W + 1));
            checkOutput("sweep_bin", 32'(bin), 32'(n));
            checkOutput("sweep_err", 32'(err), 32'd0);
        end

        // Randomized mix of valid/invalid inputs, sometimes back-to-back.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) @(negedge clk);
            if ($urandom_range(0, 3) != 0)
                v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                v = 12'($urandom);
            convertAndCheck(v, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from each digit that is >= 8.
- Accepts up to DIGITS packed BCD digits and returns an unsigned binary value after a fixed multi-cycle conversion.
- Sits between keypad/display-entry logic that produces decimal digits and counter/compare logic that consumes binary.
- Uses a start/busy/done handshake.

Parameters:
- DIGITS, 3, number of BCD digits accepted. Digit 0 is the ones digit, in bcd[3:0].
- BIN_W, 10, result width. Must satisfy 2^BIN_W > 10^DIGITS - 1. Equals the number of shift cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a conversion; sampled only when busy=0
- bcd  input  4*DIGITS  packed BCD digits, captured on the accepting edge
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; bin and err are valid from this cycle
- err  output  1  high with done when any captured digit is greater than 9
- bin  output  BIN_W  binary result, held until the next done

Behaviour:
- Reset (async, active-high): state IDLE; busy=0, done=0, err=0, bin=0; shift register and counter cleared.
- Reset mid-conversion aborts immediately. No done is produced. The pending result is discarded.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle, then returns to IDLE.
- All outputs are registered.
- Acceptance: start=1 at an edge while busy=0 (IDLE or DONE). bcd is captured into the upper 4*DIGITS bits of a working register of width 4*DIGITS+BIN_W. The lower BIN_W bits are zeroed. The cycle counter is cleared.
- Validity check happens at the accepting edge:
  - If any digit > 9: go directly to DONE with err=1, bin=0. done is high in the cycle after acceptance (latency 1).
  - Otherwise go to SHIFT with err cleared.
- Each SHIFT edge:
  - Shift the working register right by 1.
  - Then, for each digit field independently: if the field is >= 8, subtract 3 (4-bit result, no borrow between digits).
  - Increment the counter.
- At the edge completing shift number BIN_W:
  - Load bin from the lower BIN_W bits of the working register.
  - Go to DONE with done=1 and busy=0.
  - done is high in the cycle after edge BIN_W following acceptance, i.e. BIN_W cycles after the accept edge (10 with defaults).
- Start while busy=1 is ignored; bcd changes during SHIFT have no effect.
- Start asserted during the DONE cycle is accepted (back-to-back). The next done follows exactly BIN_W cycles later.
- The upper digit field is zero after BIN_W shifts for all valid inputs.
- bin and err hold their values through IDLE until the next DONE. done never asserts without a preceding accepted start.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_MAX_DIGIT=9, DD_THRESH=8, DD_CORR=3, shared with the forward binary-to-BCD converter.
  - state enum {IDLE, SHIFT, DONE}.
- One combinational sub-module, bcd_digit_corrector (4-bit in/out: subtract 3 if >= 8), instantiated DIGITS times via generate.
- Counter width is clog2(BIN_W+1).

Test Plan:
- bcd=0x255, start pulse -> busy high for 10 cycles, then done=1 one cycle with bin=255 (0x0FF), err=0.
- bcd=0x999 -> bin=999 (0x3E7), err=0. bcd=0x000 -> bin=0, done after 10 cycles.
- bcd=0x1A3 (tens digit = 10) -> done one cycle after accept, err=1, bin=0, busy never asserted.
- Start 0x123, then start=1 with bcd=0x456 at cycle 4 -> ignored, bin=123. Start 0x456 in the DONE cycle -> second done exactly 10 cycles later with bin=456.
- Start 0x777, assert reset at cycle 5 (asynchronously, mid-cycle) -> busy/done/err/bin drop to 0 immediately, no done pulse follows; a new start of 0x042 yields bin=42.
- Exhaustive sweep of 0..999 BCD compared against a decimal reference model -> all match, err=0.
